// File: rtl/data_mem_pkg.sv
// Shared types, constants and the range-check helper for the data memory responder.
package data_mem_pkg;

    // Width of the latency down-counter (latency range 1..15)
    localparam int unsigned CNT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // True when base <= addr < base + 4*2^depth_log2. The subtraction is one bit wider than
    // the operands so an address below the base shows up as a borrow, never as a wrap.
    function automatic logic addr_in_range(input logic [63:0]   addr,
                                           input logic [63:0]   base,
                                           input int unsigned   depth_log2);
        logic [64:0] diff;
        logic [64:0] span;
        diff = {1'b0, addr} - {1'b0, base};
        span = 65'd4 << depth_log2;
        return !diff[64] && (diff < span);
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port scratchpad with per-lane write enables and a registered read port.
module byte_ram #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BYTE_DATA_WIDTH = 4,
    parameter int unsigned DEPTH_LOG2      = 10
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic [BYTE_DATA_WIDTH-1:0] be_i,
    input  logic [DEPTH_LOG2-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    output logic [DATA_WIDTH-1:0]      rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Lane-masked write and registered read; no reset so the array maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < BYTE_DATA_WIDTH; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: fixed-latency scratchpad access with an
// out-of-range error flag.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH      = 32,
    parameter int unsigned          BYTE_DATA_WIDTH = 4,
    parameter int unsigned          DEPTH_LOG2      = 10,
    parameter int unsigned          LATENCY         = 2,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_req,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       inst_we,
    input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
    output logic                       data_valid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       data_err
);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                       we_q, we_d;
    logic [BYTE_DATA_WIDTH-1:0] be_q, be_d;
    logic                       valid_q, valid_d;
    logic                       err_q, err_d;
    // Set when the response carries RAM read data; gates the RAM output onto rdata
    logic                       rd_hit_q, rd_hit_d;

    logic [DATA_WIDTH-1:0]      acc_addr;
    logic [DATA_WIDTH-1:0]      acc_wdata;
    logic                       acc_we;
    logic [BYTE_DATA_WIDTH-1:0] acc_be;
    logic                       acc_in_range;
    logic                       acc_fire;
    logic [DATA_WIDTH-1:0]      offset;
    logic [DEPTH_LOG2-1:0]      ram_idx;
    logic                       ram_we;
    logic                       ram_re;
    logic [DATA_WIDTH-1:0]      ram_rdata;
    logic                       unused_offset_bits;

    // Access operands: live inputs when the access happens on the accept edge, else captured
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr  = data_addr;
            acc_wdata = wdata;
            acc_we    = inst_we;
            acc_be    = byte_enable;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_we    = we_q;
            acc_be    = be_q;
        end
    end

    assign acc_in_range = addr_in_range(64'(acc_addr), 64'(BASE_ADDR), DEPTH_LOG2);
    assign offset       = acc_addr - BASE_ADDR;
    assign ram_idx      = offset[DEPTH_LOG2+1:2];
    assign ram_we       = acc_fire & acc_we & acc_in_range;
    assign ram_re       = acc_fire & ~acc_we & acc_in_range;

    assign unused_offset_bits = ^{offset[1:0], offset[DATA_WIDTH-1:DEPTH_LOG2+2]};

    // FSM next state, latency counter, request capture and response flags
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        be_d     = be_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        rd_hit_d = 1'b0;
        acc_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_req) begin
                    addr_d  = data_addr;
                    wdata_d = wdata;
                    we_d    = inst_we;
                    be_d    = byte_enable;
                    if (LATENCY == 1) begin
                        acc_fire = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    acc_fire = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (acc_fire) begin
            valid_d  = 1'b1;
            err_d    = ~acc_in_range;
            rd_hit_d = ~acc_we & acc_in_range;
        end
    end

    // State registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            be_q     <= be_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rd_hit_q <= rd_hit_d;
        end
    end

    byte_ram #(
        .DATA_WIDTH      (DATA_WIDTH),
        .BYTE_DATA_WIDTH (BYTE_DATA_WIDTH),
        .DEPTH_LOG2      (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .be_i    (acc_be),
        .idx_i   (ram_idx),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    assign data_valid = valid_q;
    assign data_err   = err_q;
    assign rdata      = rd_hit_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 15) checked against a
// byte-level memory model with directed and random transactions.
module tb_data_mem_responder;

    localparam longint unsigned BASE  = 64'h0;
    localparam longint unsigned SPAN  = 64'd4096;
    localparam int              WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] wdata = '0;
    logic        inst_we = 1'b0;
    logic [3:0]  byte_enable = '0;
    logic [2:0]  vld;
    logic [2:0]  errs;
    logic [31:0] rd [3];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_vcyc = 0;
    logic [31:0] last_rd = '0;

    logic [31:0] mdl [3][WORDS];
    logic [3:0]  kn  [3][WORDS];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .data_req(req[0]), .data_addr(data_addr), .wdata(wdata),
        .inst_we(inst_we), .byte_enable(byte_enable), .data_valid(vld[0]), .rdata(rd[0]),
        .data_err(errs[0])
    );
    data_mem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .data_req(req[1]), .data_addr(data_addr), .wdata(wdata),
        .inst_we(inst_we), .byte_enable(byte_enable), .data_valid(vld[1]), .rdata(rd[1]),
        .data_err(errs[1])
    );
    data_mem_responder #(.LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst), .data_req(req[2]), .data_addr(data_addr), .wdata(wdata),
        .inst_we(inst_we), .byte_enable(byte_enable), .data_valid(vld[2]), .rdata(rd[2]),
        .data_err(errs[2])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance d; scr scrambles the live inputs while waiting
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic w, input logic [3:0] be, input bit scr);
        int          lat;
        int          idx;
        bit          in_rng;
        bit          early_ok;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        lat    = lat_of(d);
        in_rng = ({32'd0, a} >= BASE) && ({32'd0, a} < BASE + SPAN);
        idx    = in_rng ? int'(({32'd0, a} - BASE) >> 2) : 0;
        exp_rd = '0;
        mask   = '1;
        if (in_rng && !w) begin
            exp_rd = mdl[d][idx];
            for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{kn[d][idx][i]}};
        end
        data_addr   = a;
        wdata       = wd;
        inst_we     = w;
        byte_enable = be;
        req[d]      = 1'b1;
        early_ok    = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < lat - 1; k++) begin
            if (vld[d] !== 1'b0) early_ok = 1'b0;
            if (scr) begin
                data_addr   = $urandom;
                wdata       = $urandom;
                inst_we     = 1'($urandom_range(0, 1));
                byte_enable = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
        end
        chk("no_early_valid", 32'(early_ok), 32'd1);
        chk("valid", 32'(vld[d]), 32'd1);
        chk("err", 32'(errs[d]), 32'(!in_rng));
        chk("rdata", rd[d] & mask, exp_rd & mask);
        last_rd   = rd[d];
        last_vcyc = cyc;
        if (in_rng && w) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mdl[d][idx][i*8 +: 8] = wd[i*8 +: 8];
                    kn[d][idx][i]         = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        chk("resp_clear", {vld[d], errs[d], rd[d] != 32'd0}, 3'b000);
        req[d] = 1'b0;
    endtask

    initial begin
        int          v1;
        int          d;
        bit          quiet;
        logic [31:0] a;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < WORDS; i++) kn[j][i] = 4'h0;
        end

        // Reset state
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("reset_outputs", {vld[j], errs[j], rd[j] != 32'd0}, 3'b000);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Preload and read with LATENCY=2
        txn(0, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1'b0);
        txn(0, 32'h10, 32'h0, 1'b0, 4'h0, 1'b0);
        chk("read_0x10", last_rd, 32'hDEADBEEF);

        // Partial-lane write
        txn(0, 32'h20, 32'hAABBCCDD, 1'b1, 4'hF, 1'b0);
        txn(0, 32'h20, 32'h11223344, 1'b1, 4'b0101, 1'b0);
        txn(0, 32'h20, 32'h0, 1'b0, 4'hF, 1'b0);
        chk("partial_write", last_rd, 32'hAA22CC44);
        txn(0, 32'h20, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0);
        txn(0, 32'h20, 32'h0, 1'b0, 4'h0, 1'b0);
        chk("be_zero_noop", last_rd, 32'hAA22CC44);

        // Range boundaries
        txn(0, 32'h1000, 32'h0, 1'b0, 4'h0, 1'b0);
        txn(0, 32'h1000, 32'h55555555, 1'b1, 4'hF, 1'b0);
        txn(0, 32'hFFFF_FFFC, 32'h0, 1'b0, 4'h0, 1'b0);
        txn(0, 32'hFFC, 32'h0BADF00D, 1'b1, 4'hF, 1'b0);
        txn(0, 32'hFFF, 32'h0, 1'b0, 4'h0, 1'b0);
        chk("top_byte_read", last_rd, 32'h0BADF00D);
        txn(0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);

        // Back-to-back write then read
        txn(0, 32'h30, 32'hCAFEF00D, 1'b1, 4'hF, 1'b0);
        v1 = last_vcyc;
        txn(0, 32'h30, 32'h0, 1'b0, 4'h0, 1'b0);
        chk("b2b_data", last_rd, 32'hCAFEF00D);
        chk("b2b_spacing", 32'(last_vcyc - v1), 32'd3);

        // Reset during the response cycle drops the outputs at once
        data_addr = 32'h10; inst_we = 1'b0; byte_enable = 4'h0; req[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("valid_before_rst", 32'(vld[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_in_resp", {vld[0], errs[0], rd[0] != 32'd0}, 3'b000);
        req[0] = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("no_valid_after_rst", 32'(vld[0]), 32'd0);

        // Reset mid-WAIT of a write discards it
        txn(2, 32'h40, 32'h0, 1'b1, 4'hF, 1'b0);
        data_addr = 32'h40; wdata = 32'h12345678; inst_we = 1'b1; byte_enable = 4'hF;
        req[2] = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_in_wait", {vld[2], errs[2], rd[2] != 32'd0}, 3'b000);
        req[2] = 1'b0;
        #2 rst = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (vld[2] !== 1'b0) quiet = 1'b0;
        end
        chk("aborted_no_valid", 32'(quiet), 32'd1);
        txn(2, 32'h40, 32'h0, 1'b0, 4'h0, 1'b0);
        chk("aborted_write", last_rd, 32'h0);

        // LATENCY=1 and LATENCY=15 with inputs scrambled while waiting
        txn(1, 32'h50, 32'h01020304, 1'b1, 4'hF, 1'b1);
        txn(1, 32'h50, 32'h0, 1'b0, 4'h0, 1'b1);
        chk("lat1_read", last_rd, 32'h01020304);
        txn(2, 32'h50, 32'hA5A55A5A, 1'b1, 4'hF, 1'b1);
        txn(2, 32'h50, 32'h0, 1'b0, 4'h0, 1'b1);
        chk("lat15_read", last_rd, 32'hA5A55A5A);

        // Random transactions against the model
        for (int n = 0; n < 80; n++) begin
            d = $urandom_range(0, 7) == 0 ? 2 : int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else a = 32'h200 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            txn(d, a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
